// File: rtl/genie_split.sv
// genie_split: one valid/ready packet stream fanned out to NO sinks.
// Each beat goes to every output selected by the packet's destination mask and
// is consumed from the source once all selected outputs have accepted it.
// The mask is captured on the first beat and held for the rest of the packet.
module genie_split #(
    parameter int unsigned NO    = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_eop,
    input  logic [NO-1:0]    i_mask,
    output logic [WIDTH-1:0] o_data,
    output logic             o_eop,
    output logic [NO-1:0]    o_valid,
    input  logic [NO-1:0]    i_ready
);

    localparam logic [0:0] S_FLOW   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [NO-1:0] done_q, done_d;
    logic [NO-1:0] locked_mask_q, locked_mask_d;
    logic [NO-1:0] eff_mask;
    logic [NO-1:0] take;
    logic [NO-1:0] served;
    logic          complete;

    // Data and end-of-packet are broadcast unregistered to every output.
    assign o_data = i_data;
    assign o_eop  = i_eop;

    // Handshake: the routing mask is live on the first beat, frozen mid-packet.
    always_comb begin
        eff_mask = (state_q == S_LOCKED) ? locked_mask_q : i_mask;
        o_valid  = {NO{i_valid & ~reset}} & eff_mask & ~done_q;
        take     = o_valid & i_ready;
        // An output is satisfied if unselected, already served, or taking now.
        served   = ~eff_mask | done_q | take;
        complete = i_valid & (&served);
        o_ready  = complete & ~reset;
    end

    // Next-state: track delivered outputs and lock routing across the packet.
    always_comb begin
        state_d       = state_q;
        locked_mask_d = locked_mask_q;
        done_d        = done_q | take;
        if (complete) begin
            done_d = '0;
            if (state_q == S_FLOW) begin
                if (!i_eop) begin
                    state_d       = S_LOCKED;
                    locked_mask_d = eff_mask;
                end
            end else if (i_eop) begin
                state_d = S_FLOW;
            end
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FLOW;
            done_q        <= '0;
            locked_mask_q <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            locked_mask_q <= locked_mask_d;
        end
    end

endmodule

// File: tb/tb_genie_split.sv
// Directed testbench for genie_split with NO=4, WIDTH=8.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_genie_split;

    logic       clk;
    logic       reset;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_eop;
    logic [3:0] i_mask;
    logic [7:0] o_data;
    logic       o_eop;
    logic [3:0] o_valid;
    logic [3:0] i_ready;

    int n_checks;
    int n_fail;

    genie_split #(
        .NO   (4),
        .WIDTH(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_eop  (i_eop),
        .i_mask (i_mask),
        .o_data (o_data),
        .o_eop  (o_eop),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit the current cycle and move inputs to just after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_valid = 1'b1;
        i_mask  = 4'b1111;
        i_ready = 4'b1111;
        i_data  = 8'h3C;
        i_eop   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b0000) begin
            $display("FAIL reset_valid: got %b expected %b", o_valid, 4'b0000);
            n_fail++;
        end
        n_checks++;
        if (o_ready !== 1'b0) begin
            $display("FAIL reset_ready: got %b expected %b", o_ready, 1'b0);
            n_fail++;
        end
        n_checks++;
        if (o_data !== 8'h3C || o_eop !== 1'b1) begin
            $display("FAIL reset_passthru: got %h/%b expected 3c/1", o_data, o_eop);
            n_fail++;
        end
        next_cycle();
        reset   = 1'b0;
        i_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_unicast();
        logic [7:0] d [3];
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        i_mask  = 4'b0100;
        i_ready = 4'b1111;
        i_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            i_data = d[b];
            i_eop  = (b == 2);
            @(negedge clk);
            n_checks++;
            if (o_valid !== 4'b0100 || o_ready !== 1'b1) begin
                $display("FAIL unicast beat %0d: got valid=%b ready=%b expected 0100/1",
                         b, o_valid, o_ready);
                n_fail++;
            end
            n_checks++;
            if (o_eop !== (b == 2) || o_data !== d[b]) begin
                $display("FAIL unicast_data beat %0d: got %h/%b expected %h/%b",
                         b, o_data, o_eop, d[b], (b == 2));
                n_fail++;
            end
            next_cycle();
        end
        // Back in FLOW: a fresh single-beat packet takes its own mask.
        i_mask = 4'b0001;
        i_data = 8'h44;
        i_eop  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b0001 || o_ready !== 1'b1) begin
            $display("FAIL unicast_after: got valid=%b ready=%b expected 0001/1",
                     o_valid, o_ready);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_multicast();
        int cnt [4];
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        i_mask  = 4'b1011;
        i_data  = 8'hA5;
        i_eop   = 1'b1;
        i_valid = 1'b1;
        i_ready = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b1011 || o_ready !== 1'b0) begin
            $display("FAIL multicast_c0: got valid=%b ready=%b expected 1011/0",
                     o_valid, o_ready);
            n_fail++;
        end
        for (int j = 0; j < 4; j++) if (o_valid[j] && i_ready[j] && o_data == 8'hA5) cnt[j]++;
        next_cycle();
        i_ready = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b1010 || o_ready !== 1'b1) begin
            $display("FAIL multicast_c1: got valid=%b ready=%b expected 1010/1",
                     o_valid, o_ready);
            n_fail++;
        end
        for (int j = 0; j < 4; j++) if (o_valid[j] && i_ready[j] && o_data == 8'hA5) cnt[j]++;
        next_cycle();
        i_valid = 1'b0;
        i_ready = 4'b1111;
        @(negedge clk);
        for (int j = 0; j < 4; j++) if (o_valid[j] && i_ready[j] && o_data == 8'hA5) cnt[j]++;
        n_checks++;
        if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 0 || cnt[3] != 1) begin
            $display("FAIL multicast_count: got %0d%0d%0d%0d expected 1,1,0,1",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
            n_fail++;
        end
        next_cycle();
    endtask

    task automatic test_mask_change();
        i_ready = 4'b1111;
        i_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            i_mask = (b == 0) ? 4'b0011 : 4'b1100;
            i_data = 8'h50 + 8'(b);
            i_eop  = (b == 2);
            @(negedge clk);
            n_checks++;
            if (o_valid !== 4'b0011 || o_ready !== 1'b1) begin
                $display("FAIL mask_lock beat %0d: got valid=%b ready=%b expected 0011/1",
                         b, o_valid, o_ready);
                n_fail++;
            end
            next_cycle();
        end
        i_mask = 4'b1100;
        i_eop  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b1100) begin
            $display("FAIL mask_next_pkt: got %b expected %b", o_valid, 4'b1100);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero_mask();
        i_ready = 4'b0000;
        i_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            // Second beat offers a non-zero mask that must be ignored.
            i_mask = (b == 0) ? 4'b0000 : 4'b1111;
            i_eop  = (b == 1);
            i_data = 8'h60 + 8'(b);
            @(negedge clk);
            n_checks++;
            if (o_valid !== 4'b0000 || o_ready !== 1'b1) begin
                $display("FAIL zero_mask beat %0d: got valid=%b ready=%b expected 0000/1",
                         b, o_valid, o_ready);
                n_fail++;
            end
            next_cycle();
        end
        i_mask  = 4'b1000;
        i_ready = 4'b1000;
        i_eop   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b1000 || o_ready !== 1'b1) begin
            $display("FAIL zero_mask_after: got valid=%b ready=%b expected 1000/1",
                     o_valid, o_ready);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_valid_drop();
        i_mask  = 4'b0011;
        i_eop   = 1'b1;
        i_data  = 8'h77;
        i_valid = 1'b1;
        i_ready = 4'b0001;
        next_cycle();
        i_valid = 1'b0;
        i_ready = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b0000 || o_ready !== 1'b0) begin
            $display("FAIL drop_idle: got valid=%b ready=%b expected 0000/0", o_valid, o_ready);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b0010 || o_ready !== 1'b1) begin
            $display("FAIL drop_resume: got valid=%b ready=%b expected 0010/1",
                     o_valid, o_ready);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        i_mask  = 4'b0010;
        i_ready = 4'b1111;
        i_eop   = 1'b0;
        i_data  = 8'h81;
        i_valid = 1'b1;
        next_cycle();
        i_data  = 8'h82;
        i_mask  = 4'b0000;
        i_ready = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 4'b0010 || o_ready !== 1'b0) begin
            $display("FAIL rstmid_pre: got valid=%b ready=%b expected 0010/0", o_valid, o_ready);
            n_fail++;
        end
        #1;
        reset   = 1'b1;
        i_ready = 4'b1111;
        #1;
        n_checks++;
        if (o_valid !== 4'b0000 || o_ready !== 1'b0) begin
            $display("FAIL rstmid_async: got valid=%b ready=%b expected 0000/0",
                     o_valid, o_ready);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        i_mask = 4'b0001;
        i_eop  = 1'b1;
        i_data = 8'h90;
        #1;
        n_checks++;
        if (o_valid !== 4'b0001 || o_ready !== 1'b1) begin
            $display("FAIL rstmid_after: got valid=%b ready=%b expected 0001/1",
                     o_valid, o_ready);
            n_fail++;
        end
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_eop    = 1'b0;
        i_mask   = '0;
        i_ready  = '0;
        #1;
        test_reset();
        test_unicast();
        test_multicast();
        test_mask_change();
        test_zero_mask();
        test_valid_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
